// File: rtl/call_pkg.sv
// ---------------------------------------------------------------------------
// call_pkg
//
// Shared definitions for the CALL micro-op path (call_fsm -> call_exec_unit).
//   - 16-bit micro-op codes issued by the call FSM.
//   - Sequencing state enum, shared by the FSM and the execution unit.
//
// Configuration macro used by the units that import this package:
//   CALL_EXEC_OVF_EN  - enables the stack-overflow guard and stack_ovf port.
// ---------------------------------------------------------------------------
package call_pkg;

  localparam int unsigned UOP_W = 16;

  // Micro-op codes. Code 1 doubles as the FSM's idle code, which is why
  // uop_valid, not the code itself, decides whether anything happens.
  localparam logic [UOP_W-1:0] PUSH_PC_LOW  = 16'd1;
  localparam logic [UOP_W-1:0] PUSH_PC_HIGH = 16'd2;
  localparam logic [UOP_W-1:0] MOV_PC_LOW   = 16'd3;
  localparam logic [UOP_W-1:0] MOV_PC_HIGH  = 16'd4;

  // Each state names the last micro-op that completed legally.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PL_DONE = 2'd1,
    PH_DONE = 2'd2,
    ML_DONE = 2'd3
  } call_state_e;

endpackage : call_pkg

// File: rtl/call_sp_reg.sv
// ---------------------------------------------------------------------------
// call_sp_reg
//
// Stack-pointer register for the CALL execution unit. Post-decrements on
// every accepted push; the caller writes at the pre-decrement value.
//
// Configuration: CALL_EXEC_OVF_EN
//   defined   - a push attempted at sp == 0 is refused: sp holds at 0,
//               push_ok drops so the caller suppresses its write, and the
//               sticky stack_ovf flag is set until reset.
//   undefined - sp wraps modulo 2**ADDR_W; push_ok is always 1 and the
//               stack_ovf port does not exist.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   push      in   a push is being accepted this cycle
//   sp        out  current stack pointer (registered)
//   push_ok   out  combinational: the push may write and decrement
//   stack_ovf out  sticky overflow flag (CALL_EXEC_OVF_EN only)
// ---------------------------------------------------------------------------
module call_sp_reg #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  output logic [ADDR_W-1:0] sp,
  output logic              push_ok
`ifdef CALL_EXEC_OVF_EN
  ,
  output logic              stack_ovf
`endif
);

`ifdef CALL_EXEC_OVF_EN
  assign push_ok = (sp != '0);
`else
  assign push_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= ADDR_W'(SP_RESET);
    end else if (push && push_ok) begin
      // Wraps 0 -> all-ones naturally when the guard is compiled out.
      sp <= sp - ADDR_W'(1);
    end
  end

`ifdef CALL_EXEC_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_ovf <= 1'b0;
    end else if (push && !push_ok) begin
      stack_ovf <= 1'b1;
    end
  end
`endif

endmodule : call_sp_reg

// File: rtl/call_exec_unit.sv
// ---------------------------------------------------------------------------
// call_exec_unit
//
// Executes the CALL micro-op sequence from call_fsm:
//   PUSH_PC_LOW -> PUSH_PC_HIGH -> MOV_PC_LOW -> MOV_PC_HIGH
// pushing the two return-PC halves on the data-memory stack, assembling the
// target PC from the two MOV halves and issuing one pc_load pulse. Any
// out-of-order or unknown code pulses seq_err and returns to IDLE; a
// PUSH_PC_LOW always (re)starts a sequence.
//
// All outputs are registered and appear one cycle after the accepting edge.
//
// Configuration: CALL_EXEC_OVF_EN (see call_sp_reg) adds the stack_ovf port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   uop        in   micro-op code (call_pkg codes)
//   uop_valid  in   uop is accepted only when 1
//   ret_pc     in   return address to push
//   target     in   call target to load into the PC
//   mem_we     out  stack write strobe, one cycle per push
//   mem_addr   out  stack write address (pre-decrement sp)
//   mem_wdata  out  stack write data
//   sp         out  current stack pointer
//   pc_load    out  one-cycle pulse, fetch loads pc_next
//   pc_next    out  assembled target PC
//   busy       out  high from an accepted PUSH_PC_LOW until pc_load
//   seq_err    out  one-cycle pulse on an illegal micro-op
//   stack_ovf  out  sticky overflow flag (CALL_EXEC_OVF_EN only)
// ---------------------------------------------------------------------------
module call_exec_unit
  import call_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       uop,
  input  logic              uop_valid,
  input  logic [31:0]       ret_pc,
  input  logic [31:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] sp,
  output logic              pc_load,
  output logic [31:0]       pc_next,
  output logic              busy,
  output logic              seq_err
`ifdef CALL_EXEC_OVF_EN
  ,
  output logic              stack_ovf
`endif
);

  call_state_e state, state_nxt;

  logic        push_lo, push_hi, mov_lo, mov_hi, err;
  logic        push, push_ok;
  // Only the upper half is needed later; the lower half is written at once.
  logic [15:0] ret_hi;

  // -------------------------------------------------------------------------
  // Micro-op decode / next state
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    push_lo   = 1'b0;
    push_hi   = 1'b0;
    mov_lo    = 1'b0;
    mov_hi    = 1'b0;
    err       = 1'b0;

    if (uop_valid) begin
      case (uop)
        PUSH_PC_LOW: begin
          // Legal from anywhere; mid-sequence it still flags the aborted
          // sequence but starts the new one cleanly.
          push_lo   = 1'b1;
          err       = (state != IDLE);
          state_nxt = PL_DONE;
        end
        PUSH_PC_HIGH: begin
          if (state == PL_DONE) begin
            push_hi   = 1'b1;
            state_nxt = PH_DONE;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end
        MOV_PC_LOW: begin
          if (state == PH_DONE) begin
            mov_lo    = 1'b1;
            state_nxt = ML_DONE;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end
        MOV_PC_HIGH: begin
          if (state == ML_DONE) begin
            mov_hi    = 1'b1;
            state_nxt = IDLE;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign push = push_lo | push_hi;

  // -------------------------------------------------------------------------
  // Stack pointer
  // -------------------------------------------------------------------------
  call_sp_reg #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp_reg (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .sp        (sp),
    .push_ok   (push_ok)
`ifdef CALL_EXEC_OVF_EN
    ,
    .stack_ovf (stack_ovf)
`endif
  );

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ret_hi    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc_load   <= 1'b0;
      pc_next   <= '0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      seq_err <= err;
      pc_load <= mov_hi;
      mem_we  <= push && push_ok;

      if (push) begin
        // Address is the pre-decrement sp; call_sp_reg decrements on the
        // same edge, so both show up together.
        mem_addr  <= sp;
        mem_wdata <= push_lo ? ret_pc[15:0] : ret_hi;
      end

      if (push_lo) begin
        ret_hi <= ret_pc[31:16];
      end

      // Halves are written independently so an aborted sequence leaves
      // whatever was already assembled.
      if (mov_lo) begin
        pc_next[15:0] <= target[15:0];
      end
      if (mov_hi) begin
        pc_next[31:16] <= target[31:16];
      end
    end
  end

endmodule : call_exec_unit
